// File: rtl/wave_gen_pkg.sv
// Shared types and calibration constants for the multi-channel waveform generator.
package wave_gen_pkg;

  typedef enum logic [1:0] {
    MODE_TRI = 2'd0,
    MODE_SAW = 2'd1,
    MODE_SQR = 2'd2,
    MODE_DC  = 2'd3
  } wave_mode_e;

  localparam int unsigned CFG_W     = 16;
  localparam int unsigned S2_W      = 12;
  localparam int          S2_MAX    = 2047;
  localparam int          S2_MIN    = -2048;
  localparam int          CAL_MID   = 2048;
  localparam int unsigned CAL_SHIFT = 11;

  localparam int CAL_SLOPE [2] = '{1961, 1947};
  localparam int CAL_ICPT  [2] = '{24, 33};

  // Per-channel configuration presented to one channel instance.
  typedef struct packed {
    wave_mode_e               mode;
    logic signed [CFG_W-1:0]  step_val;
    logic        [CFG_W-1:0]  half_count;
    logic signed [CFG_W-1:0]  dc_ofs;
  } ch_cfg_t;

  // Channels beyond the calibrated pair reuse the table alternately.
  function automatic int cal_slope(input int ch);
    return CAL_SLOPE[ch[0]];
  endfunction

  function automatic int cal_icpt(input int ch);
    return CAL_ICPT[ch[0]];
  endfunction

endpackage

// File: rtl/wave_gen_channel.sv
// One waveform channel: S1 waveform accumulator, S2 offset/scale/saturate,
// S3 linear calibration into an unsigned DAC code.
module wave_gen_channel
  import wave_gen_pkg::*;
#(
  parameter int unsigned ACC_W = 19,
  parameter int unsigned DAC_W = 12,
  parameter int          SLOPE = 1961,
  parameter int          ICPT  = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe,
  input  logic             enable,
  input  ch_cfg_t          cfg,
  output logic [DAC_W-1:0] dac_word,
  output logic             sample_valid
);

  localparam int DAC_MAX = (1 << DAC_W) - 1;

  logic signed [ACC_W-1:0] acc, acc_base, acc_nxt, step_ext;
  logic        [CFG_W-1:0] cnt, cnt_base, cnt_nxt;
  logic                    dir, dir_base, dir_nxt;
  logic                    wrap;
  wave_mode_e              mode_q;
  logic signed [CFG_W-1:0] dc_q;
  logic                    v1, v2;
  logic                    accept;

  logic signed [ACC_W:0]   sum, shr;
  logic signed [S2_W-1:0]  s2_nxt, s2_q;
  logic signed [31:0]      prod, cal;
  logic        [DAC_W-1:0] dac_nxt;

  assign accept = strobe & enable;

  // S1: a mode change restarts the waveform from a clean state.
  always_comb begin
    acc_base = (cfg.mode != mode_q) ? '0 : acc;
    cnt_base = (cfg.mode != mode_q) ? '0 : cnt;
    dir_base = (cfg.mode != mode_q) ? 1'b0 : dir;
    step_ext = ACC_W'(cfg.step_val);
    wrap     = (cnt_base == cfg.half_count);
    acc_nxt  = acc_base;
    cnt_nxt  = wrap ? '0 : cnt_base + 16'd1;
    dir_nxt  = wrap ? ~dir_base : dir_base;
    unique case (cfg.mode)
      MODE_TRI: acc_nxt = dir_base ? acc_base + step_ext : acc_base - step_ext;
      MODE_SAW: begin
        acc_nxt = wrap ? -acc_base : acc_base + step_ext;
        dir_nxt = dir_base;
      end
      MODE_SQR: acc_nxt = dir_base ? step_ext : -step_ext;
      MODE_DC: begin
        acc_nxt = '0;
        cnt_nxt = cnt_base;
        dir_nxt = dir_base;
      end
    endcase
  end

  // S2: offset at one extra bit of headroom, divide by 8, saturate.
  always_comb begin
    sum    = (ACC_W+1)'(acc) + (ACC_W+1)'(dc_q);
    shr    = sum >>> 3;
    s2_nxt = S2_W'(shr);
    if (shr > (ACC_W+1)'(S2_MAX)) begin
      s2_nxt = S2_W'(S2_MAX);
    end else if (shr < (ACC_W+1)'(S2_MIN)) begin
      s2_nxt = S2_W'(S2_MIN);
    end
  end

  // S3: gain/intercept correction around midscale, clamped to the DAC range.
  always_comb begin
    prod    = 32'(s2_q) * 32'(SLOPE);
    cal     = (prod >>> CAL_SHIFT) + 32'(ICPT) + 32'(CAL_MID);
    dac_nxt = DAC_W'(cal);
    if (cal < 0) begin
      dac_nxt = '0;
    end else if (cal > 32'(DAC_MAX)) begin
      dac_nxt = DAC_W'(DAC_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= '0;
      cnt          <= '0;
      dir          <= 1'b0;
      mode_q       <= MODE_TRI;
      dc_q         <= '0;
      v1           <= 1'b0;
      v2           <= 1'b0;
      s2_q         <= '0;
      dac_word     <= DAC_W'(CAL_MID);
      sample_valid <= 1'b0;
    end else begin
      // Dropping enable discards samples still in flight.
      v1           <= accept;
      v2           <= v1 & enable;
      sample_valid <= v2 & enable;
      if (accept) begin
        acc    <= acc_nxt;
        cnt    <= cnt_nxt;
        dir    <= dir_nxt;
        mode_q <= cfg.mode;
        dc_q   <= cfg.dc_ofs;
      end
      if (v1 & enable) begin
        s2_q <= s2_nxt;
      end
      if (v2 & enable) begin
        dac_word <= dac_nxt;
      end
    end
  end

endmodule

// File: rtl/wave_gen_multi.sv
// Multi-channel waveform generator: NUM_CH independent channels sharing one
// sample strobe.
module wave_gen_multi
  import wave_gen_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ACC_W  = 19,
  parameter int unsigned DAC_W  = 12
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clk_sampling,
  input  logic [NUM_CH-1:0]                 enable,
  input  logic [NUM_CH-1:0][1:0]            mode,
  input  logic [NUM_CH-1:0][CFG_W-1:0]      step_val,
  input  logic [NUM_CH-1:0][CFG_W-1:0]      half_count,
  input  logic [NUM_CH-1:0][CFG_W-1:0]      dc_ofs,
  output logic [NUM_CH-1:0][DAC_W-1:0]      dac_word,
  output logic [NUM_CH-1:0]                 sample_valid
);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    ch_cfg_t cfg;

    assign cfg = '{mode:       wave_mode_e'(mode[ch]),
                   step_val:   step_val[ch],
                   half_count: half_count[ch],
                   dc_ofs:     dc_ofs[ch]};

    wave_gen_channel #(
      .ACC_W (ACC_W),
      .DAC_W (DAC_W),
      .SLOPE (cal_slope(ch)),
      .ICPT  (cal_icpt(ch))
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .strobe       (clk_sampling),
      .enable       (enable[ch]),
      .cfg          (cfg),
      .dac_word     (dac_word[ch]),
      .sample_valid (sample_valid[ch])
    );
  end

endmodule
